// File: rtl/bram_write_packer_pkg.sv
// Shared definitions for the BRAM write packer: header layout, target codes,
// FSM state encoding and small header decode helpers.
package bram_write_packer_pkg;

    localparam int WORD_BYTES_DEF = 16;
    localparam int CNT_W_DEF      = 16;

    localparam int HDR_TGT_MSB = 7;
    localparam int HDR_TGT_LSB = 6;
    localparam int HDR_CNT_MSB = 5;
    localparam int HDR_CNT_LSB = 0;
    localparam int HDR_CNT_W   = HDR_CNT_MSB - HDR_CNT_LSB + 1;

    typedef enum logic [1:0] {
        TGT_INPUT    = 2'b00,
        TGT_TEMPLATE = 2'b01,
        TGT_FF       = 2'b10,
        TGT_ILLEGAL  = 2'b11
    } target_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_WAIT = 2'd2
    } state_e;

    function automatic target_e hdr_target(input logic [7:0] hdr);
        return target_e'(hdr[HDR_TGT_MSB:HDR_TGT_LSB]);
    endfunction

    // Header carries N-1, so the count needs one extra bit to hold N=64.
    function automatic logic [HDR_CNT_W:0] hdr_word_count(input logic [7:0] hdr);
        return {1'b0, hdr[HDR_CNT_MSB:HDR_CNT_LSB]} + (HDR_CNT_W + 1)'(1);
    endfunction

    // Strobe vector ordering: {input, template, ff}.
    function automatic logic [2:0] target_strobe(input target_e tgt);
        logic [2:0] s;
        s = 3'b000;
        case (tgt)
            TGT_INPUT:    s = 3'b100;
            TGT_TEMPLATE: s = 3'b010;
            TGT_FF:       s = 3'b001;
            default:      s = 3'b000;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/bram_write_packer_word_assembler.sv
// MSB-first byte shifter: packs accepted bytes into one write word and flags
// the byte that completes it.
module bram_write_packer_word_assembler
    import bram_write_packer_pkg::*;
#(
    parameter int WORD_BYTES = WORD_BYTES_DEF
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    clear,
    input  logic                    shift_en,
    input  logic [7:0]              byte_in,
    output logic [8*WORD_BYTES-1:0] word_data,
    output logic                    word_full
);

    localparam int IDX_W = (WORD_BYTES > 1) ? $clog2(WORD_BYTES) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WORD_BYTES - 1);

    logic [IDX_W-1:0] byte_idx;

    // Asserted in the same cycle as the acceptance of the final byte.
    assign word_full = shift_en && (byte_idx == LAST_IDX);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            word_data <= '0;
            byte_idx  <= '0;
        end else begin
            if (shift_en) begin
                word_data <= {word_data[8*WORD_BYTES-9:0], byte_in};
            end
            if (clear) begin
                byte_idx <= '0;
            end else if (shift_en) begin
                byte_idx <= word_full ? '0 : byte_idx + IDX_W'(1);
            end
        end
    end

endmodule

// File: rtl/bram_write_packer.sv
// Byte-stream ingest ahead of the BRAM controller: decodes a packet header,
// assembles 128-bit words and issues one write strobe per word.
//
// state   | meaning
// IDLE    | waiting for a header byte; illegal headers set ERROR and are dropped
// LOAD    | accepting payload bytes into the current word
// WAIT    | word complete, input stalled until the controller raises READY
module bram_write_packer
    import bram_write_packer_pkg::*;
#(
    parameter int WORD_BYTES = WORD_BYTES_DEF,
    parameter int CNT_W      = CNT_W_DEF
) (
    input  logic                    CLK,
    input  logic                    RST,
    input  logic [7:0]              RX_DATA,
    input  logic                    RX_VALID,
    output logic                    RX_READY,
    input  logic                    READY,
    output logic                    INPUT_WRITE,
    output logic                    TEMPLATE_WRITE,
    output logic                    FF_WRITE,
    output logic [8*WORD_BYTES-1:0] WRITE_DATA,
    output logic                    BUSY,
    output logic                    ERROR,
    output logic [CNT_W-1:0]        WORDS_WRITTEN
);

    state_e                 state_q;
    state_e                 state_d;
    target_e                target_q;
    logic [HDR_CNT_W:0]     remaining_q;
    logic                   rx_ready_q;
    logic                   rx_ready_d;
    logic [2:0]             strobe_q;
    logic [2:0]             strobe_d;
    logic                   error_q;
    logic [CNT_W-1:0]       words_q;

    logic                   rx_fire;
    logic                   hdr_fire;
    logic                   hdr_legal;
    logic                   load_fire;
    logic                   write_fire;
    logic                   word_full;

    assign rx_fire    = RX_VALID && rx_ready_q;
    assign hdr_fire   = rx_fire && (state_q == ST_IDLE);
    assign hdr_legal  = (hdr_target(RX_DATA) != TGT_ILLEGAL);
    assign load_fire  = rx_fire && (state_q == ST_LOAD);
    assign write_fire = (state_q == ST_WAIT) && READY;

    bram_write_packer_word_assembler #(
        .WORD_BYTES (WORD_BYTES)
    ) u_word_assembler (
        .clk       (CLK),
        .rst_n     (RST),
        .clear     (hdr_fire && hdr_legal),
        .shift_en  (load_fire),
        .byte_in   (RX_DATA),
        .word_data (WRITE_DATA),
        .word_full (word_full)
    );

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (hdr_fire && hdr_legal) begin
                    state_d = ST_LOAD;
                end
            end
            ST_LOAD: begin
                if (word_full) begin
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (READY) begin
                    state_d = (remaining_q > (HDR_CNT_W + 1)'(1)) ? ST_LOAD : ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Ready and strobes are computed one cycle early and registered so that
    // neither RX_VALID nor READY has a combinational path to an output.
    always_comb begin
        rx_ready_d = (state_d != ST_WAIT);
        strobe_d   = write_fire ? target_strobe(target_q) : 3'b000;
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            rx_ready_q  <= 1'b0;
            strobe_q    <= 3'b000;
            target_q    <= TGT_INPUT;
            remaining_q <= '0;
            error_q     <= 1'b0;
            words_q     <= '0;
        end else begin
            rx_ready_q <= rx_ready_d;
            strobe_q   <= strobe_d;
            if (hdr_fire) begin
                if (hdr_legal) begin
                    target_q    <= hdr_target(RX_DATA);
                    remaining_q <= hdr_word_count(RX_DATA);
                end else begin
                    error_q <= 1'b1;
                end
            end
            if (write_fire) begin
                remaining_q <= remaining_q - (HDR_CNT_W + 1)'(1);
                words_q     <= words_q + CNT_W'(1);
            end
        end
    end

    assign RX_READY       = rx_ready_q;
    assign INPUT_WRITE    = strobe_q[2];
    assign TEMPLATE_WRITE = strobe_q[1];
    assign FF_WRITE       = strobe_q[0];
    assign BUSY           = (state_q != ST_IDLE);
    assign ERROR          = error_q;
    assign WORDS_WRITTEN  = words_q;

endmodule

// File: tb/tb_bram_write_packer.sv
// Directed and randomized checks of bram_write_packer against a word-level
// reference queue of expected (target, word) writes.
module tb_bram_write_packer;

    logic         CLK;
    logic         RST;
    logic [7:0]   RX_DATA;
    logic         RX_VALID;
    logic         RX_READY;
    logic         READY;
    logic         INPUT_WRITE;
    logic         TEMPLATE_WRITE;
    logic         FF_WRITE;
    logic [127:0] WRITE_DATA;
    logic         BUSY;
    logic         ERROR;
    logic [15:0]  WORDS_WRITTEN;

    bram_write_packer #(
        .WORD_BYTES (16),
        .CNT_W      (16)
    ) dut (
        .CLK            (CLK),
        .RST            (RST),
        .RX_DATA        (RX_DATA),
        .RX_VALID       (RX_VALID),
        .RX_READY       (RX_READY),
        .READY          (READY),
        .INPUT_WRITE    (INPUT_WRITE),
        .TEMPLATE_WRITE (TEMPLATE_WRITE),
        .FF_WRITE       (FF_WRITE),
        .WRITE_DATA     (WRITE_DATA),
        .BUSY           (BUSY),
        .ERROR          (ERROR),
        .WORDS_WRITTEN  (WORDS_WRITTEN)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    typedef struct packed {
        logic [1:0]   tgt;
        logic [127:0] data;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    int   exp_ww = 0;
    int   cnt_in = 0;
    int   cnt_tmpl = 0;
    int   cnt_ff = 0;
    bit   prev_strobe = 1'b0;
    bit   rand_ready = 1'b0;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [2:0] exp_strobe(input logic [1:0] tgt);
        case (tgt)
            2'b00:   return 3'b100;
            2'b01:   return 3'b010;
            2'b10:   return 3'b001;
            default: return 3'b000;
        endcase
    endfunction

    // Every strobe must match the oldest outstanding expected write.
    task automatic monitor();
        logic [2:0] s;
        exp_t       e;
        int         n;
        s = {INPUT_WRITE, TEMPLATE_WRITE, FF_WRITE};
        n = $countones(s);
        if (n > 1) chk("strobe_onehot", 128'(n), 128'(1));
        if (n == 1) begin
            if (prev_strobe) chk("strobe_width", 128'(prev_strobe), 128'(0));
            if (exp_q.size() == 0) begin
                chk("spurious_strobe", 128'(s), 128'(0));
            end else begin
                e = exp_q.pop_front();
                chk("strobe_target", 128'(s), 128'(exp_strobe(e.tgt)));
                chk("write_data", WRITE_DATA, e.data);
                exp_ww = (exp_ww + 1) % 65536;
                chk("words_written", 128'(WORDS_WRITTEN), 128'(exp_ww));
            end
            if (s[2]) cnt_in++;
            if (s[1]) cnt_tmpl++;
            if (s[0]) cnt_ff++;
        end
        prev_strobe = (n != 0);
    endtask

    task automatic tick();
        @(negedge CLK);
        if (rand_ready) READY = 1'($urandom_range(1, 0));
        monitor();
    endtask

    task automatic send_byte(input logic [7:0] b, input bit gaps);
        int budget;
        if (gaps) begin
            while ($urandom_range(1, 0) == 1) begin
                RX_VALID = 1'b0;
                tick();
            end
        end
        RX_DATA  = b;
        RX_VALID = 1'b1;
        budget   = 0;
        while (RX_READY !== 1'b1 && budget < 1000) begin
            tick();
            budget++;
        end
        if (budget >= 1000) chk("rx_accept_timeout", 128'(0), 128'(1));
        tick();
        RX_VALID = 1'b0;
    endtask

    task automatic send_word(input logic [1:0] tgt, input logic [127:0] w, input bit gaps);
        exp_t e;
        e.tgt  = tgt;
        e.data = w;
        exp_q.push_back(e);
        for (int i = 0; i < 16; i++) send_byte(w[127-8*i -: 8], gaps);
    endtask

    function automatic logic [127:0] rand_word();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic send_packet(input logic [1:0] tgt, input int n, input bit gaps);
        send_byte({tgt, 6'(n - 1)}, gaps);
        for (int w = 0; w < n; w++) send_word(tgt, rand_word(), gaps);
    endtask

    task automatic wait_idle();
        int budget;
        budget = 0;
        while ((exp_q.size() != 0 || BUSY !== 1'b0) && budget < 5000) begin
            tick();
            budget++;
        end
        if (budget >= 5000) chk("idle_timeout", 128'(0), 128'(1));
    endtask

    task automatic check_reset_values(input string tag);
        chk({tag, "_rx_ready"}, 128'(RX_READY), 128'(0));
        chk({tag, "_strobes"}, 128'({INPUT_WRITE, TEMPLATE_WRITE, FF_WRITE}), 128'(0));
        chk({tag, "_write_data"}, WRITE_DATA, 128'(0));
        chk({tag, "_busy"}, 128'(BUSY), 128'(0));
        chk({tag, "_error"}, 128'(ERROR), 128'(0));
        chk({tag, "_words"}, 128'(WORDS_WRITTEN), 128'(0));
    endtask

    initial begin
        logic [127:0] w;
        int           base;

        RST      = 1'b0;
        RX_DATA  = 8'h00;
        RX_VALID = 1'b0;
        READY    = 1'b0;
        repeat (3) tick();
        check_reset_values("reset");
        RST = 1'b1;
        tick();
        chk("post_reset_rx_ready", 128'(RX_READY), 128'(1));
        chk("post_reset_busy", 128'(BUSY), 128'(0));

        // Single input word with known bytes; check exact strobe latency.
        READY = 1'b1;
        for (int i = 0; i < 16; i++) w[127-8*i -: 8] = 8'(i);
        send_byte(8'h00, 1'b0);
        chk("load_busy", 128'(BUSY), 128'(1));
        send_word(2'b00, w, 1'b0);
        chk("t1_rx_ready_wait", 128'(RX_READY), 128'(0));
        chk("t1_no_early_strobe", 128'(INPUT_WRITE), 128'(0));
        chk("t1_data_known", WRITE_DATA, 128'h000102030405060708090a0b0c0d0e0f);
        tick();
        chk("t1_input_write", 128'(INPUT_WRITE), 128'(1));
        chk("t1_busy_done", 128'(BUSY), 128'(0));
        chk("t1_words", 128'(WORDS_WRITTEN), 128'(1));
        tick();
        chk("t1_strobe_drop", 128'(INPUT_WRITE), 128'(0));

        // Template packet of three words.
        base = cnt_tmpl;
        send_byte(8'h42, 1'b0);
        for (int k = 0; k < 3; k++) begin
            send_word(2'b01, rand_word(), 1'b0);
            chk("t2_rx_ready_low", 128'(RX_READY), 128'(0));
        end
        wait_idle();
        chk("t2_template_count", 128'(cnt_tmpl - base), 128'(3));

        // FF word stalled by the controller.
        READY = 1'b0;
        w = rand_word();
        send_byte(8'h80, 1'b0);
        send_word(2'b10, w, 1'b0);
        for (int c = 0; c < 20; c++) begin
            chk("t3_no_ff_write", 128'(FF_WRITE), 128'(0));
            chk("t3_rx_ready_stall", 128'(RX_READY), 128'(0));
            chk("t3_data_stable", WRITE_DATA, w);
            chk("t3_busy_stall", 128'(BUSY), 128'(1));
            tick();
        end
        READY = 1'b1;
        tick();
        chk("t3_ff_write", 128'(FF_WRITE), 128'(1));
        wait_idle();

        // Illegal header is dropped and latches ERROR.
        base = exp_ww;
        send_byte(8'hC5, 1'b0);
        tick();
        chk("t4_error_set", 128'(ERROR), 128'(1));
        chk("t4_busy_idle", 128'(BUSY), 128'(0));
        chk("t4_words_unchanged", 128'(WORDS_WRITTEN), 128'(base));
        send_packet(2'b00, 1, 1'b0);
        wait_idle();
        chk("t4_error_sticky", 128'(ERROR), 128'(1));
        chk("t4_word_after_error", 128'(WORDS_WRITTEN), 128'(base + 1));

        // Reset in the middle of a word.
        send_byte(8'h40, 1'b0);
        exp_q.push_back('{2'b01, 128'(0)});
        for (int i = 0; i < 7; i++) send_byte(8'($urandom), 1'b0);
        #2;
        RST = 1'b0;
        exp_q.delete();
        exp_ww = 0;
        prev_strobe = 1'b0;
        #1;
        check_reset_values("midreset");
        tick();
        tick();
        RST = 1'b1;
        tick();
        chk("midreset_rx_ready", 128'(RX_READY), 128'(1));
        send_packet(2'b00, 1, 1'b0);
        wait_idle();
        chk("midreset_words", 128'(WORDS_WRITTEN), 128'(1));

        // Maximum packet with random RX_VALID gaps.
        base = cnt_in;
        send_packet(2'b00, 64, 1'b1);
        wait_idle();
        chk("t6_input_count", 128'(cnt_in - base), 128'(64));
        chk("t6_words", 128'(WORDS_WRITTEN), 128'(65));

        // Random targets and sizes with random READY and gaps.
        rand_ready = 1'b1;
        for (int p = 0; p < 4; p++) begin
            send_packet(2'($urandom_range(2, 0)), int'($urandom_range(4, 1)), 1'b1);
        end
        wait_idle();
        rand_ready = 1'b0;
        READY = 1'b1;
        chk("t7_all_written", 128'(exp_q.size()), 128'(0));
        chk("t7_words", 128'(WORDS_WRITTEN), 128'(exp_ww));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
